rx_align_ctrl: RTL and testbench

Word-alignment training controller for the LVDS 7:1 receive path. It sits in the deserializer word-clock domain between the per-lane deserializer and the RX data-synchronisation stage. It compares the deserialized clock-lane word against the known 7-bit clock pattern and issues single-cycle bit-slip commands until the pattern is found. Once aligned it enables the sync stage, then monitors alignment and re-trains automatically on lock loss.

---
 rtl/rx_align_ctrl.sv | 179 +++++++++++++++++
 tb/tb_rx_align_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_align_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rx_align_ctrl                                                 |
// | Purpose  : Word-alignment training controller for the LVDS 7:1 receive   |
// |            path. Compares the deserialized clock-lane word against the   |
// |            known clock pattern and issues single-cycle bit-slip commands |
// |            until the pattern is found. Once aligned it enables the RX    |
// |            sync stage, monitors alignment and re-trains on lock loss.    |
// | Ports    : WCLK        word clock (only clock)                          |
// |            RESET       asynchronous active-low reset                    |
// |            START       level, starts training in IDLE or FAIL           |
// |            DATA_VALID  qualifies CLK_WORD                               |
// |            CLK_WORD    deserialized clock-lane word [6:0]               |
// |            BITSLIP     one-cycle slip command                           |
// |            SYNC_EN     sync-stage enable, high while locked             |
// |            ALIGN_DONE  high while locked                                |
// |            ALIGN_FAIL  high while in FAIL                               |
// |            LOCK_LOST   one-cycle pulse on LOCKED->SETTLE                |
// |            SLIP_CNT    slips issued in the current sweep [2:0]          |
// |            STATE       current state [2:0]                              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rx_align_ctrl #(
   parameter logic [6:0] PATTERN        = 7'b1100011,
   parameter int         SETTLE_CYCLES  = 8,
   parameter int         CHECK_WORDS    = 4,
   parameter int         MISMATCH_LIMIT = 3,
   parameter int         MAX_SLIPS      = 6
) (
   input  logic       WCLK,
   input  logic       RESET,
   input  logic       START,
   input  logic       DATA_VALID,
   input  logic [6:0] CLK_WORD,
   output logic       BITSLIP,
   output logic       SYNC_EN,
   output logic       ALIGN_DONE,
   output logic       ALIGN_FAIL,
   output logic       LOCK_LOST,
   output logic [2:0] SLIP_CNT,
   output logic [2:0] STATE
);

   // Terminal counts: each counter counts from 0, so the transition fires
   // when the counter already holds the last value before the limit.
   localparam logic [7:0] c_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [3:0] c_CHECK_LAST  = 4'(CHECK_WORDS - 1);
   localparam logic [3:0] c_MISS_LAST   = 4'(MISMATCH_LIMIT - 1);
   localparam logic [2:0] c_MAX_SLIPS   = 3'(MAX_SLIPS);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_CHECK  = 3'd2,
      ST_SLIP   = 3'd3,
      ST_LOCKED = 3'd4,
      ST_FAIL   = 3'd5
   } state_t;

   state_t     r_state,      w_state_nxt;
   logic [7:0] r_settle_cnt, w_settle_nxt;
   logic [3:0] r_match_cnt,  w_match_nxt;
   logic [3:0] r_miss_cnt,   w_miss_nxt;
   logic [2:0] r_slip_cnt,   w_slip_nxt;
   logic       r_lock_lost,  w_lock_lost_nxt;

   logic       w_word_hit;
   logic       w_word_miss;

   assign w_word_hit  = DATA_VALID && (CLK_WORD == PATTERN);
   assign w_word_miss = DATA_VALID && (CLK_WORD != PATTERN);

   always_ff @(posedge WCLK or negedge RESET) begin
      if (!RESET) begin
         r_state      <= ST_IDLE;
         r_settle_cnt <= 8'd0;
         r_match_cnt  <= 4'd0;
         r_miss_cnt   <= 4'd0;
         r_slip_cnt   <= 3'd0;
         r_lock_lost  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_settle_cnt <= w_settle_nxt;
         r_match_cnt  <= w_match_nxt;
         r_miss_cnt   <= w_miss_nxt;
         r_slip_cnt   <= w_slip_nxt;
         r_lock_lost  <= w_lock_lost_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_settle_nxt    = r_settle_cnt;
      w_match_nxt     = r_match_cnt;
      w_miss_nxt      = r_miss_cnt;
      w_slip_nxt      = r_slip_cnt;
      w_lock_lost_nxt = 1'b0;

      case (r_state)
         ST_IDLE, ST_FAIL: begin
            // SLIP_CNT holds in FAIL so the failed sweep stays visible.
            if (START) begin
               w_state_nxt  = ST_SETTLE;
               w_settle_nxt = 8'd0;
               w_match_nxt  = 4'd0;
               w_slip_nxt   = 3'd0;
            end
         end

         ST_SETTLE: begin
            if (r_settle_cnt == c_SETTLE_LAST) begin
               w_state_nxt  = ST_CHECK;
               w_settle_nxt = 8'd0;
               w_match_nxt  = 4'd0;
            end else begin
               w_settle_nxt = r_settle_cnt + 8'd1;
            end
         end

         ST_CHECK: begin
            if (w_word_hit) begin
               if (r_match_cnt == c_CHECK_LAST) begin
                  w_state_nxt = ST_LOCKED;
                  w_match_nxt = 4'd0;
                  w_miss_nxt  = 4'd0;
               end else begin
                  w_match_nxt = r_match_cnt + 4'd1;
               end
            end else if (w_word_miss) begin
               // Slips are only entered below the limit, so SLIP_CNT
               // can never pass MAX_SLIPS or wrap.
               if (r_slip_cnt < c_MAX_SLIPS) begin
                  w_state_nxt = ST_SLIP;
               end else begin
                  w_state_nxt = ST_FAIL;
               end
            end
         end

         ST_SLIP: begin
            w_state_nxt  = ST_SETTLE;
            w_settle_nxt = 8'd0;
            w_slip_nxt   = r_slip_cnt + 3'd1;
         end

         ST_LOCKED: begin
            if (w_word_hit) begin
               w_miss_nxt = 4'd0;
            end else if (w_word_miss) begin
               if (r_miss_cnt == c_MISS_LAST) begin
                  w_state_nxt     = ST_SETTLE;
                  w_settle_nxt    = 8'd0;
                  w_miss_nxt      = 4'd0;
                  w_slip_nxt      = 3'd0;
                  w_lock_lost_nxt = 1'b1;
               end else begin
                  w_miss_nxt = r_miss_cnt + 4'd1;
               end
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Decoded from the state register only; an asynchronous reset forces
   // ST_IDLE, so a reset landing in ST_SLIP drops BITSLIP at once.
   assign BITSLIP    = (r_state == ST_SLIP);
   assign SYNC_EN    = (r_state == ST_LOCKED);
   assign ALIGN_DONE = (r_state == ST_LOCKED);
   assign ALIGN_FAIL = (r_state == ST_FAIL);
   assign LOCK_LOST  = r_lock_lost;
   assign SLIP_CNT   = r_slip_cnt;
   assign STATE      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rx_align_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rx_align_ctrl                                              |
// | Purpose  : Directed self-checking bench for rx_align_ctrl.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_rx_align_ctrl;

   localparam logic [6:0] c_PAT     = 7'b1100011;
   localparam logic [6:0] c_ROT_PAT = 7'b1000111;

   logic       WCLK = 1'b0;
   logic       RESET;
   logic       START;
   logic       DATA_VALID;
   logic [6:0] CLK_WORD;
   logic       BITSLIP;
   logic       SYNC_EN;
   logic       ALIGN_DONE;
   logic       ALIGN_FAIL;
   logic       LOCK_LOST;
   logic [2:0] SLIP_CNT;
   logic [2:0] STATE;

   int checks   = 0;
   int failures = 0;

   rx_align_ctrl u_dut (
      .WCLK       (WCLK),
      .RESET      (RESET),
      .START      (START),
      .DATA_VALID (DATA_VALID),
      .CLK_WORD   (CLK_WORD),
      .BITSLIP    (BITSLIP),
      .SYNC_EN    (SYNC_EN),
      .ALIGN_DONE (ALIGN_DONE),
      .ALIGN_FAIL (ALIGN_FAIL),
      .LOCK_LOST  (LOCK_LOST),
      .SLIP_CNT   (SLIP_CNT),
      .STATE      (STATE)
   );

   always #5 WCLK = ~WCLK;

   task automatic step();
      @(posedge WCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_low(input string tag);
      chk({tag, "_state"},      {29'd0, STATE},      32'd0);
      chk({tag, "_bitslip"},    {31'd0, BITSLIP},    32'd0);
      chk({tag, "_sync_en"},    {31'd0, SYNC_EN},    32'd0);
      chk({tag, "_align_done"}, {31'd0, ALIGN_DONE}, 32'd0);
      chk({tag, "_align_fail"}, {31'd0, ALIGN_FAIL}, 32'd0);
      chk({tag, "_lock_lost"},  {31'd0, LOCK_LOST},  32'd0);
      chk({tag, "_slip_cnt"},   {29'd0, SLIP_CNT},   32'd0);
   endtask

   task automatic do_reset();
      RESET      = 1'b0;
      START      = 1'b0;
      DATA_VALID = 1'b0;
      CLK_WORD   = 7'd0;
      step();
      step();
      RESET = 1'b1;
      step();
   endtask

   task automatic start_pulse();
      START = 1'b1;
      step();
      START = 1'b0;
   endtask

   // Drives a deserializer model: the word is correct once align_after slips
   // have been applied, otherwise bad_word. Runs until STATE==target or the
   // cycle bound expires, checking BITSLIP pulse shape and spacing.
   task automatic run_until(input logic [2:0] target, input int bound,
                            input int align_after, input logic [6:0] bad_word,
                            output int nslips);
      int   last_t;
      logic prev_bs;
      nslips  = 0;
      last_t  = 0;
      prev_bs = 1'b0;
      for (int cyc = 0; cyc < bound; cyc++) begin
         DATA_VALID = 1'b1;
         CLK_WORD   = (nslips >= align_after) ? c_PAT : bad_word;
         step();
         if (BITSLIP) begin
            chk("bitslip_single", {31'd0, prev_bs}, 32'd0);
            if (nslips > 0)
               chk("slip_spacing_ge10", {31'd0, ((cyc - last_t) >= 10)}, 32'd1);
            nslips++;
            last_t = cyc;
         end
         prev_bs = BITSLIP;
         if (STATE == target) break;
      end
      chk("reach_state", {29'd0, STATE}, {29'd0, target});
   endtask

   initial begin
      int   ns;
      logic bs_seen;
      logic [6:0] ll_words [6];

      // ---- reset state
      RESET      = 1'b0;
      START      = 1'b0;
      DATA_VALID = 1'b0;
      CLK_WORD   = 7'd0;
      step();
      chk_all_low("reset");
      RESET = 1'b1;
      step();
      chk("idle_no_start", {29'd0, STATE}, 32'd0);

      // ---- aligned: START driven after edge n, LOCKED after edge n+13
      CLK_WORD   = c_PAT;
      DATA_VALID = 1'b1;
      START      = 1'b1;
      step();                                        // edge n+1
      chk("aligned_settle_n1", {29'd0, STATE}, 32'd1);
      START   = 1'b0;
      bs_seen = 1'b0;
      for (int k = 2; k <= 13; k++) begin
         step();
         bs_seen = bs_seen | BITSLIP;
         if (k == 8)  chk("aligned_settle_n8", {29'd0, STATE}, 32'd1);
         if (k == 9)  chk("aligned_check_n9",  {29'd0, STATE}, 32'd2);
         if (k == 12) chk("aligned_check_n12", {29'd0, STATE}, 32'd2);
      end
      chk("aligned_locked_n13", {29'd0, STATE},      32'd4);
      chk("aligned_sync_en",    {31'd0, SYNC_EN},    32'd1);
      chk("aligned_align_done", {31'd0, ALIGN_DONE}, 32'd1);
      chk("aligned_slip_cnt",   {29'd0, SLIP_CNT},   32'd0);
      chk("aligned_no_bitslip", {31'd0, bs_seen},    32'd0);

      // ---- lock loss: miss, miss, hit, miss, miss, miss
      ll_words[0] = 7'h00;
      ll_words[1] = 7'h00;
      ll_words[2] = c_PAT;
      ll_words[3] = 7'h00;
      ll_words[4] = 7'h00;
      ll_words[5] = 7'h00;
      for (int i = 0; i < 6; i++) begin
         CLK_WORD = ll_words[i];
         step();
         if (i < 5) begin
            chk("ll_still_locked", {29'd0, STATE},     32'd4);
            chk("ll_no_pulse",     {31'd0, LOCK_LOST}, 32'd0);
         end
      end
      chk("ll_state_settle", {29'd0, STATE},      32'd1);
      chk("ll_pulse",        {31'd0, LOCK_LOST},  32'd1);
      chk("ll_sync_en_low",  {31'd0, SYNC_EN},    32'd0);
      chk("ll_done_low",     {31'd0, ALIGN_DONE}, 32'd0);
      chk("ll_slip_cnt",     {29'd0, SLIP_CNT},   32'd0);
      CLK_WORD = c_PAT;
      step();
      chk("ll_pulse_one_cycle", {31'd0, LOCK_LOST}, 32'd0);

      // ---- valid gaps: lock after 4 valid words over 8 CHECK cycles
      do_reset();
      CLK_WORD   = c_PAT;
      DATA_VALID = 1'b1;
      start_pulse();                                 // edge n+1
      repeat (8) step();                             // edge n+9
      chk("gaps_check_entry", {29'd0, STATE}, 32'd2);
      for (int k = 0; k < 8; k++) begin
         DATA_VALID = (k % 2 == 1);
         CLK_WORD   = (k % 2 == 1) ? c_PAT : 7'h00;  // invalid words are garbage
         step();
         if (k < 7) chk("gaps_still_check", {29'd0, STATE}, 32'd2);
      end
      chk("gaps_locked", {29'd0, STATE}, 32'd4);

      // ---- offset 3: pattern appears after 3 slips
      do_reset();
      start_pulse();
      run_until(3'd4, 300, 3, c_ROT_PAT, ns);
      chk("off3_slips",    ns,                  32'd3);
      chk("off3_slip_cnt", {29'd0, SLIP_CNT},   32'd3);
      chk("off3_sync_en",  {31'd0, SYNC_EN},    32'd1);

      // ---- never matches: 6 slips then FAIL
      do_reset();
      start_pulse();
      run_until(3'd5, 400, 99, 7'h00, ns);
      chk("fail_slips",      ns,                  32'd6);
      chk("fail_align_fail", {31'd0, ALIGN_FAIL}, 32'd1);
      chk("fail_slip_cnt",   {29'd0, SLIP_CNT},   32'd6);
      chk("fail_sync_en",    {31'd0, SYNC_EN},    32'd0);
      repeat (3) step();
      chk("fail_hold_state", {29'd0, STATE},    32'd5);
      chk("fail_hold_slips", {29'd0, SLIP_CNT}, 32'd6);
      start_pulse();
      chk("restart_state",      {29'd0, STATE},      32'd1);
      chk("restart_slip_cnt",   {29'd0, SLIP_CNT},   32'd0);
      chk("restart_align_fail", {31'd0, ALIGN_FAIL}, 32'd0);

      // ---- reset during SLIP (second slip of the sweep, SLIP_CNT=1)
      run_until(3'd3, 50, 99, 7'h00, ns);
      run_until(3'd3, 50, 99, 7'h00, ns);
      chk("midslip_bitslip_before", {31'd0, BITSLIP},  32'd1);
      chk("midslip_cnt_before",     {29'd0, SLIP_CNT}, 32'd1);
      RESET = 1'b0;
      #1;
      chk_all_low("midslip_async");
      step();
      RESET      = 1'b1;
      START      = 1'b0;
      DATA_VALID = 1'b1;
      CLK_WORD   = c_PAT;
      repeat (3) step();
      chk("midslip_stays_idle", {29'd0, STATE}, 32'd0);
      start_pulse();
      run_until(3'd4, 100, 0, 7'h00, ns);
      chk("midslip_retrain_slips", ns,                32'd0);
      chk("midslip_retrain_cnt",   {29'd0, SLIP_CNT}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
